// File: rtl/seq_shift_add_mult.sv
// Radix-2 shift-and-add unsigned multiplier: one partial product per clock,
// WIDTH cycles per product, with a start/busy/done handshake.
module seq_shift_add_mult #(
   parameter int WIDTH = 3,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] z
);

   // Handshake: start is accepted only in IDLE (busy=0); operands are captured
   // on that edge. done pulses for exactly one cycle when z takes a new product.
   typedef enum logic {IDLE, RUN} state_e;

   localparam int PW = 2 * WIDTH;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [PW-1:0]    z_q, z_d;

   logic [PW-1:0]    addend;
   logic [PW-1:0]    acc_sum;

   assign addend  = mplier_q[0] ? mcand_q : '0;
   assign acc_sum = acc_q + addend;

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      z_d      = z_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d  = {{WIDTH{1'b0}}, a};
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            // The last partial product is folded straight into z rather than
            // waiting an extra cycle for acc to settle.
            if (cnt_q == LAST_CNT) begin
               z_d     = acc_sum;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         z_q      <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         z_q      <= z_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign z    = z_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult at WIDTH 1, 3, 4 and 8; inputs change
// and outputs are sampled on the falling clock edge.
module tb_seq_shift_add_mult;

   logic clk;
   logic rst_n;

   int n_tests;
   int n_fail;

   logic        start3, busy3, done3;
   logic [2:0]  a3, b3;
   logic [5:0]  z3;

   logic        start8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] z8;

   logic        start4, busy4, done4;
   logic [3:0]  a4, b4;
   logic [7:0]  z4;

   logic        start1, busy1, done1;
   logic [0:0]  a1, b1;
   logic [1:0]  z1;

   seq_shift_add_mult #(.WIDTH(3)) u_w3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
      .busy(busy3), .done(done3), .z(z3)
   );
   seq_shift_add_mult #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .z(z8)
   );
   seq_shift_add_mult #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .z(z4)
   );
   seq_shift_add_mult #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .z(z1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0;
      start3 = 0; a3 = 0; b3 = 0;
      start8 = 0; a8 = 0; b8 = 0;
      start4 = 0; a4 = 0; b4 = 0;
      start1 = 0; a1 = 0; b1 = 0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({busy3, done3, busy8, done8, busy4, done4, busy1, done1} !== 8'b0 ||
          z3 !== 6'd0 || z8 !== 16'd0 || z4 !== 8'd0 || z1 !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state: busy/done=%b z3=%0d z8=%0d z4=%0d z1=%0d required all 0",
                  {busy3, done3, busy8, done8, busy4, done4, busy1, done1}, z3, z8, z4, z1);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // All 64 operand pairs; busy high for k=1..3 and done only at k=4.
   task automatic test_exhaustive_w3();
      logic [3:0] busy_seq, done_seq;
      logic [5:0] z_seen;
      for (int ai = 0; ai < 8; ai++) begin
         for (int bi = 0; bi < 8; bi++) begin
            start3 = 1'b1; a3 = 3'(ai); b3 = 3'(bi);
            busy_seq = '0; done_seq = '0; z_seen = '0;
            for (int k = 1; k <= 4; k++) begin
               @(negedge clk);
               if (k == 1) begin
                  start3 = 1'b0; a3 = 3'(~ai); b3 = 3'(~bi);
               end
               busy_seq[k-1] = busy3;
               done_seq[k-1] = done3;
               if (k == 4) z_seen = z3;
            end
            n_tests++;
            if (busy_seq !== 4'b0111 || done_seq !== 4'b1000) begin
               n_fail++;
               $display("FAIL w3_timing %0d*%0d: busy=%b done=%b required busy=0111 done=1000",
                        ai, bi, busy_seq, done_seq);
            end
            n_tests++;
            if (z_seen !== 6'(ai * bi)) begin
               n_fail++;
               $display("FAIL w3_product %0d*%0d: z=%0d required %0d", ai, bi, z_seen, ai * bi);
            end
         end
      end
   endtask

   task automatic test_wide_w8();
      logic [7:0]  ta [2];
      logic [7:0]  tb [2];
      logic [15:0] te [2];
      logic [8:0]  done_seq;
      logic [15:0] z_seen;
      ta[0] = 8'd255; tb[0] = 8'd255; te[0] = 16'd65025;
      ta[1] = 8'd0;   tb[1] = 8'd200; te[1] = 16'd0;
      for (int t = 0; t < 2; t++) begin
         start8 = 1'b1; a8 = ta[t]; b8 = tb[t];
         done_seq = '0; z_seen = '0;
         for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) start8 = 1'b0;
            done_seq[k-1] = done8;
            if (k == 9) z_seen = z8;
         end
         n_tests++;
         if (done_seq !== 9'b1_0000_0000 || z_seen !== te[t]) begin
            n_fail++;
            $display("FAIL w8_product %0d*%0d: z=%0d done=%b required z=%0d done=100000000",
                     ta[t], tb[t], z_seen, done_seq, te[t]);
         end
      end
   endtask

   // A second start while busy must be ignored: one done, product 3*5.
   task automatic test_start_while_busy();
      int pulses;
      logic [7:0] done_seq;
      logic [5:0] z_seen;
      pulses = 0; done_seq = '0; z_seen = '0;
      start3 = 1'b1; a3 = 3'd3; b3 = 3'd5;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         done_seq[k-1] = done3;
         if (done3) begin
            pulses++;
            z_seen = z3;
         end
         if (k == 1) start3 = 1'b0;
         if (k == 2) begin
            start3 = 1'b1; a3 = 3'd7; b3 = 3'd7;
         end
         if (k == 3) start3 = 1'b0;
      end
      n_tests++;
      if (pulses != 1 || done_seq !== 8'b0000_1000) begin
         n_fail++;
         $display("FAIL busy_ignore_done: pulses=%0d done=%b required 1 pulse, done=00001000",
                  pulses, done_seq);
      end
      n_tests++;
      if (z_seen !== 6'd15) begin
         n_fail++;
         $display("FAIL busy_ignore_z: z=%0d required 15", z_seen);
      end
   endtask

   // start held high; new operands presented in the done cycle.
   task automatic test_back_to_back();
      logic [9:0] busy_seq, done_seq;
      logic [5:0] z_first, z_second;
      busy_seq = '0; done_seq = '0; z_first = '0; z_second = '0;
      start3 = 1'b1; a3 = 3'd2; b3 = 3'd3;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         busy_seq[k-1] = busy3;
         done_seq[k-1] = done3;
         if (k == 4) begin
            z_first = z3;
            a3 = 3'd7; b3 = 3'd7;
         end
         if (k == 8) begin
            z_second = z3;
            start3 = 1'b0;
         end
      end
      n_tests++;
      if (busy_seq !== 10'b00_0111_0111 || done_seq !== 10'b00_1000_1000) begin
         n_fail++;
         $display("FAIL b2b_timing: busy=%b done=%b required busy=0001110111 done=0010001000",
                  busy_seq, done_seq);
      end
      n_tests++;
      if (z_first !== 6'd6 || z_second !== 6'd49) begin
         n_fail++;
         $display("FAIL b2b_products: z=%0d,%0d required 6,49", z_first, z_second);
      end
   endtask

   task automatic test_async_reset_w4();
      logic [4:0] done_seq;
      logic [7:0] z_seen;
      int late_done;
      // Leave a nonzero product in z so the reset has something to clear.
      start4 = 1'b1; a4 = 4'd3; b4 = 4'd5;
      done_seq = '0; z_seen = '0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) start4 = 1'b0;
         done_seq[k-1] = done4;
         if (k == 5) z_seen = z4;
      end
      n_tests++;
      if (done_seq !== 5'b10000 || z_seen !== 8'd15) begin
         n_fail++;
         $display("FAIL w4_pre: z=%0d done=%b required z=15 done=10000", z_seen, done_seq);
      end

      start4 = 1'b1; a4 = 4'd15; b4 = 4'd15;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy4 !== 1'b1) begin
         n_fail++;
         $display("FAIL w4_running: busy=%b required 1", busy4);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || z4 !== 8'd0) begin
         n_fail++;
         $display("FAIL async_reset: busy=%b done=%b z=%0d required 0 0 0", busy4, done4, z4);
      end
      late_done = 0;
      repeat (2) begin
         @(negedge clk);
         if (done4 !== 1'b0) late_done++;
      end
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (done4 !== 1'b0 || busy4 !== 1'b0) late_done++;
      end
      n_tests++;
      if (late_done != 0) begin
         n_fail++;
         $display("FAIL abort_no_done: %0d cycles with done/busy set, required 0", late_done);
      end

      start4 = 1'b1; a4 = 4'd9; b4 = 4'd9;
      done_seq = '0; z_seen = '0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) start4 = 1'b0;
         done_seq[k-1] = done4;
         if (k == 5) z_seen = z4;
      end
      n_tests++;
      if (done_seq !== 5'b10000 || z_seen !== 8'd81) begin
         n_fail++;
         $display("FAIL w4_after_reset: z=%0d done=%b required z=81 done=10000", z_seen, done_seq);
      end
   endtask

   task automatic test_width1();
      logic [1:0] busy_seq, done_seq;
      logic [1:0] z_seen;
      logic [1:0] z_exp;
      for (int t = 0; t < 4; t++) begin
         start1 = 1'b1; a1 = 1'(t >> 1); b1 = 1'(t);
         z_exp = (t == 3) ? 2'd1 : 2'd0;
         busy_seq = '0; done_seq = '0; z_seen = '0;
         for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            if (k == 1) start1 = 1'b0;
            busy_seq[k-1] = busy1;
            done_seq[k-1] = done1;
            if (k == 2) z_seen = z1;
         end
         n_tests++;
         if (busy_seq !== 2'b01 || done_seq !== 2'b10 || z_seen !== z_exp) begin
            n_fail++;
            $display("FAIL w1_product case %0d: z=%0d busy=%b done=%b required z=%0d busy=01 done=10",
                     t, z_seen, busy_seq, done_seq, z_exp);
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_exhaustive_w3();
      test_wide_w8();
      test_start_while_busy();
      test_back_to_back();
      test_async_reset_w4();
      test_width1();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Parametrised sequential unsigned multiplier using a radix-2 shift-and-add datapath.
- Successor to the single-cycle registered lookup multiplier, for operand widths where a full product table is impractical.
- Fixed latency of WIDTH cycles per product, with a start/busy/done handshake.
- Used as a shared arithmetic resource behind small control FSMs in the exercise designs.

Parameters:
WIDTH, 3, operand width in bits (legal 1..16); product width is 2*WIDTH.
CNT_W, $clog2(WIDTH)+1, width of the internal iteration counter (derived; do not override).

Ports:
clk      input   1          rising-edge clock
rst_n    input   1          asynchronous active-low reset
start    input   1          request a new multiplication; sampled only when idle
a        input   WIDTH      multiplicand, captured on the accepted start edge
b        input   WIDTH      multiplier, captured on the accepted start edge
busy     output  1          high while an operation is in progress
done     output  1          one-cycle pulse: z holds a new valid product
z        output  2*WIDTH    registered product; holds its value until the next completion

Behaviour:
- Clock and reset
  - One clock, clk.
  - Reset is asynchronous and active-low on rst_n.
  - All outputs are registered.
- Reset state
  - State IDLE; busy=0, done=0, z=0.
  - Internal accumulator, shifted multiplicand, multiplier and counter all cleared.
- Reset mid-operation
  - Aborts immediately and returns to IDLE with all outputs at their reset values.
  - No done pulse is issued for the aborted operation.
- FSM has two states, IDLE and RUN.
- IDLE
  - If start=1 at a clk edge:
    - mcand <= zero-extended a (2*WIDTH bits)
    - mplier <= b
    - acc <= 0
    - cnt <= 0
    - busy <= 1
    - done <= 0
    - go to RUN
  - Otherwise done <= 0 and z holds its value.
- RUN, on each edge
  - if mplier[0]=1 then acc <= acc + mcand
  - mcand <= mcand << 1
  - mplier <= mplier >> 1
  - cnt <= cnt + 1
- Completion, on the RUN edge where cnt == WIDTH-1
  - z <= acc + (mplier[0] ? mcand : 0)
  - done <= 1, busy <= 0, go to IDLE
- Latency
  - start is accepted at edge E.
  - z becomes valid and done is high in the cycle following edge E+WIDTH.
  - Throughput is one product per WIDTH+1 cycles when start is held high.
- Arithmetic
  - Unsigned only.
  - acc and mcand are 2*WIDTH bits; a max*max product does not overflow.
  - No truncation or saturation.
- start while busy=1 is ignored. Changes on a/b during RUN have no effect, since the operands were captured at start.
- start asserted in the same cycle as done: the FSM is in IDLE, so the new operation is accepted. done deasserts on that edge and busy reasserts.
- start held high continuously: back-to-back operations run with one IDLE cycle between them. Each result gets exactly one done pulse.
- Zero operands complete with the same fixed latency; there is no early termination.
- WIDTH=1: one RUN cycle, z = {1'b0, a&b}.

Test Plan:
- WIDTH=3, exhaustive a,b in 0..7, one start per idle cycle -> each z equals a*b (e.g. 7*7 gives z=49, 5*6 gives z=30); done is high exactly 3 cycles after the start edge; busy is high for those 3 cycles.
- WIDTH=8, a=255, b=255 -> z=65025 with done after 8 cycles; then a=0, b=200 -> z=0, still after 8 cycles.
- WIDTH=3, start a=3, b=5; pulse start again with a=7, b=7 while busy -> z=15 and only one done pulse; the second request is ignored.
- WIDTH=3, start held high, with a/b set to a new pair in the cycle done pulses -> results 6 then 49 (2*3 then 7*7), done pulses 4 cycles apart, busy low for exactly one cycle between operations.
- WIDTH=4, start a=15, b=15; assert rst_n=0 asynchronously two cycles later -> busy, done and z go to 0 immediately with no clock edge needed; no done follows.
- Then release reset and start a=9, b=9 -> z=81 after 4 cycles.
